// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller for a registered-read dual-port RAM.
// It owns the read/write pointers, the occupancy count, the status flags and
// the sticky error flags. rd_valid is aligned to the RAM's one-cycle read latency.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   flush               synchronous clear (lower priority than rst_n)
//   wr_en, wr_data      push request and data
//   rd_en               pop request
//   rd_data, rd_valid   pop data (ram_rd_data passed through) and its strobe
//   full, empty         count == depth, count == 0
//   almost_full         count >= ALMOST_FULL
//   count               occupancy (ADDR_WIDTH+1 bits)
//   overflow/underflow  sticky: push while full / pop while empty
//   ram_wr_*            RAM write port (combinational)
//   ram_rd_addr         RAM read address (combinational)
//   ram_rd_data         RAM registered read data
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ALMOST_FULL = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] DEPTH_LVL = PTR_W'(1 << ADDR_WIDTH);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(ALMOST_FULL);

    logic [PTR_W-1:0] wptr_q, wptr_n;
    logic [PTR_W-1:0] rptr_q, rptr_n;
    logic [PTR_W-1:0] count_q, count_n;
    logic             full_q, full_n;
    logic             empty_q, empty_n;
    logic             af_q, af_n;
    logic             ovf_q, ovf_n;
    logic             unf_q, unf_n;
    logic             rdv_q, rdv_n;
    logic             push, pop;

    // Requests are qualified only by registered flags, never by each other.
    assign push = wr_en & ~full_q;
    assign pop  = rd_en & ~empty_q;

    // RAM ports; a write is suppressed in a reset or flush cycle.
    assign ram_wr_en   = push & rst_n & ~flush;
    assign ram_wr_addr = wptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data = wr_data;
    assign ram_rd_addr = rptr_q[ADDR_WIDTH-1:0];

    assign rd_data     = ram_rd_data;
    assign rd_valid    = rdv_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // Next-state: pointers, count, sticky errors and the read strobe.
    always_comb begin
        wptr_n  = wptr_q;
        rptr_n  = rptr_q;
        count_n = count_q;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        rdv_n   = 1'b0;
        if (flush) begin
            wptr_n  = '0;
            rptr_n  = '0;
            count_n = '0;
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
        end else begin
            if (push) wptr_n = wptr_q + PTR_W'(1);
            if (pop)  rptr_n = rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_n = count_q + PTR_W'(1);
                2'b01:   count_n = count_q - PTR_W'(1);
                default: count_n = count_q;
            endcase
            ovf_n = ovf_q | (wr_en & full_q);
            unf_n = unf_q | (rd_en & empty_q);
            rdv_n = pop;
        end
        // Status flags are registered copies of the next-state count.
        full_n  = (count_n == DEPTH_LVL);
        empty_n = (count_n == '0);
        af_n    = (count_n >= AF_LVL);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_n;
            rptr_q  <= rptr_n;
            count_q <= count_n;
            full_q  <= full_n;
            empty_q <= empty_n;
            af_q    <= af_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
            rdv_q   <= rdv_n;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (depth 16) with a registered-read RAM alongside it.
// A queue-based model is checked every negedge; directed steps add literal checks.
module tb_fifo_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, overflow, underflow;
    logic [AW:0]   count;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_wr_en;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data;

    int total = 0;
    int bad   = 0;

    fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Registered-read RAM.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO contents as a queue plus the sticky flags.
    logic [DW-1:0] q[$];
    bit            m_ovf = 0, m_unf = 0, m_rdv = 0, chk_on = 0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk) begin
        chk_on = 1;
        if (!rst_n || flush) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_rdv = 0;
        end else begin
            bit do_pop, do_push;
            do_pop  = rd_en && q.size() > 0;
            do_push = wr_en && q.size() < DEPTH;
            if (wr_en && q.size() == DEPTH) m_ovf = 1;
            if (rd_en && q.size() == 0)     m_unf = 1;
            m_rdv = do_pop;
            if (do_pop)  m_rdata = q.pop_front();
            if (do_push) q.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
            if (m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdata));
            chk("ram_wr_en", 32'(ram_wr_en),
                32'(rst_n && !flush && wr_en && q.size() < DEPTH));
        end
    end

    // Apply inputs for one cycle; returns 2 time units after the edge.
    task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset for two cycles, with a push requested that must not reach the RAM.
        rst_n = 1'b0;
        cyc(1, 8'h11, 0, 0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        cyc(1, 8'h11, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;

        // Single word: push in N, pop in N+1, data in N+2.
        cyc(1, 8'hA5, 0, 0);
        chk("single_empty", 32'(empty), 32'd0);
        chk("single_count", 32'(count), 32'd1);
        cyc(0, 8'h00, 1, 0);
        chk("single_rd_valid", 32'(rd_valid), 32'd1);
        chk("single_rd_data", 32'(rd_data), 32'hA5);
        chk("single_count0", 32'(count), 32'd0);
        chk("single_empty1", 32'(empty), 32'd1);

        // Fill to 16, then one rejected push.
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0);
            if (i == 10) chk("af_at_11", 32'(almost_full), 32'd0);
            if (i == 11) chk("af_at_12", 32'(almost_full), 32'd1);
            if (i == 14) chk("full_at_15", 32'(full), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1, 8'hFF, 0, 0);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_count", 32'(count), 32'd16);

        // Drain 17 back-to-back pops.
        for (int i = 0; i < 17; i++) begin
            cyc(0, 8'h00, 1, 0);
            if (i < 16) begin
                chk("drain_valid", 32'(rd_valid), 32'd1);
                chk("drain_data", 32'(rd_data), 32'(i));
            end
        end
        chk("drain_valid_end", 32'(rd_valid), 32'd0);
        chk("drain_underflow", 32'(underflow), 32'd1);
        chk("drain_empty", 32'(empty), 32'd1);

        // Clear sticky flags, then steady state at count 5 with wrapping pointers.
        cyc(0, 8'h00, 0, 1);
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_unf", 32'(underflow), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'(8'h20 + i), 1, 0);
            chk("stream_count", 32'(count), 32'd5);
            chk("stream_data", 32'(rd_data), (i < 5) ? 32'(8'h10 + i) : 32'(8'h20 + i - 5));
        end
        chk("stream_ovf", 32'(overflow), 32'd0);

        // Full plus simultaneous push and pop: only the pop is taken.
        for (int i = 0; i < 11; i++) cyc(1, 8'(8'h50 + i), 0, 0);
        chk("pre_full", 32'(full), 32'd1);
        cyc(1, 8'h77, 1, 0);
        chk("fpp_count", 32'(count), 32'd15);
        chk("fpp_overflow", 32'(overflow), 32'd1);
        chk("fpp_full", 32'(full), 32'd0);
        chk("fpp_rd_data", 32'(rd_data), 32'h43);

        // Flush mid-stream with count 7.
        for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
        chk("pre_flush_count", 32'(count), 32'd7);
        cyc(1, 8'h99, 1, 1);
        chk("flush_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_rd_valid", 32'(rd_valid), 32'd0);
        chk("flush_overflow", 32'(overflow), 32'd0);
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("post_flush_valid", 32'(rd_valid), 32'd1);
        chk("post_flush_data", 32'(rd_data), 32'h3C);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
